// File: rtl/pcihellocore_led_pwm_driver.sv
// LED PWM driver fed by the green-LED PIO word: mask, 8-bit PWM duty, blink, invert.
// Config is adopted only at PWM frame boundaries. Define LED_GAMMA_EN for gamma-mapped duty.
module pcihellocore_led_pwm_driver #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pattern_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                frame_tick,
    output logic                cfg_pending
);

    typedef struct packed {
        logic [10:0] rsvd;
        logic        invert;
        logic [3:0]  blink;
        logic [7:0]  duty;
        logic [7:0]  mask;
    } led_cfg_t;

    localparam int              PRE_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
    localparam led_cfg_t        RESET_CFG = 32'h0000_00FF;

    led_cfg_t         pattern_q;
    led_cfg_t         active_cfg;
    led_cfg_t         active_cfg_d;
    logic [PRE_W-1:0] prescaler;
    logic [7:0]       pwm_cnt;
    logic [14:0]      frame_cnt;
    logic             step;
    logic             boundary;
    logic             load;
    logic             duty_full;
    logic [7:0]       duty_val;
    logic             pwm_on;
    logic             blink_on;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        step         = (prescaler == PRE_MAX);
        boundary     = step && (pwm_cnt == 8'hFF);
        load         = boundary && (pattern_q != active_cfg);
        active_cfg_d = load ? pattern_q : active_cfg;
    end

`ifdef LED_GAMMA_EN
    logic [15:0] gamma_sq;
    logic [7:0]  gamma_d;
    logic        duty_full_q;
    logic [7:0]  duty_q;

    // Gamma duty is computed from the config being loaded, so it lands with active_cfg.
    always_comb begin
        gamma_sq = 16'(active_cfg_d.duty) * 16'(active_cfg_d.duty);
        gamma_d  = 8'(gamma_sq >> 8);
        if (gamma_d == 8'd0) begin
            gamma_d = 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_full_q <= 1'b1;
            duty_q      <= 8'd1;
        end else begin
            duty_full_q <= (active_cfg_d.duty == 8'd0);
            duty_q      <= gamma_d;
        end
    end

    assign duty_full = duty_full_q;
    assign duty_val  = duty_q;
`else
    assign duty_full = (active_cfg.duty == 8'd0);
    assign duty_val  = active_cfg.duty;
`endif

    always_comb begin
        pwm_on   = duty_full || (pwm_cnt < duty_val);
        blink_on = 1'b1;
        if (active_cfg.blink != 4'd0) begin
            blink_on = ~frame_cnt[active_cfg.blink - 4'd1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q   <= RESET_CFG;
            active_cfg  <= RESET_CFG;
            cfg_pending <= 1'b0;
            frame_tick  <= 1'b0;
            prescaler   <= '0;
            pwm_cnt     <= 8'd0;
            frame_cnt   <= 15'd0;
            led_out     <= '0;
        end else begin
            pattern_q   <= pattern_in;
            cfg_pending <= (pattern_q != active_cfg);
            frame_tick  <= boundary;
            prescaler   <= step ? '0 : prescaler + 1'b1;
            active_cfg  <= active_cfg_d;
            if (step) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            // A fresh config restarts the blink phase in its on half.
            if (boundary) begin
                frame_cnt <= load ? 15'd0 : frame_cnt + 15'd1;
            end
            led_out <= (active_cfg.mask[NUM_LEDS-1:0] & {NUM_LEDS{pwm_on & blink_on}})
                       ^ {NUM_LEDS{active_cfg.invert}};
        end
    end

endmodule

// File: tb/tb_pcihellocore_led_pwm_driver.sv
// Directed bench for pcihellocore_led_pwm_driver with NUM_LEDS=8, CLK_DIV=1 (256-cycle frame).
// Expectations follow LED_GAMMA_EN when it is defined for the build.
module tb_pcihellocore_led_pwm_driver;

    localparam int NUM_LEDS = 8;
    localparam int CLK_DIV  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pattern_in = 32'h0000_00FF;
    logic [7:0]  led_out;
    logic        frame_tick;
    logic        cfg_pending;

    int checks   = 0;
    int failures = 0;

    logic [7:0] led_hist  [256];
    logic       tick_hist [256];
    logic       pend_hist [256];

    pcihellocore_led_pwm_driver #(
        .NUM_LEDS (NUM_LEDS),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pattern_in  (pattern_in),
        .led_out     (led_out),
        .frame_tick  (frame_tick),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample index i holds the LED value produced from pwm_cnt == i.
    task automatic capture_frame(input int change_at, input logic [31:0] change_val);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            led_hist[i]  = led_out;
            tick_hist[i] = frame_tick;
            pend_hist[i] = cfg_pending;
            if (i == change_at) pattern_in = change_val;
        end
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 600);
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL %s: no frame_tick within 600 cycles, frame_tick=%b required 1", name, frame_tick);
        end
    endtask

    // Called on a frame_tick sample; returns on the tick where the new config is loaded.
    task automatic apply_cfg(input logic [31:0] v);
        pattern_in = v;
        wait_tick("load_boundary");
    endtask

    function automatic int frame_diff(input logic [7:0] e0, input logic [7:0] e1, input int split);
        for (int i = 0; i < 256; i++) begin
            if (led_hist[i] !== ((i < split) ? e0 : e1)) return i;
        end
        return -1;
    endfunction

    function automatic int tick_diff();
        for (int i = 0; i < 256; i++) begin
            if (tick_hist[i] !== 1'(i == 255)) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        pattern_in = 32'h0000_00FF;
        repeat (3) @(negedge clk);
        checks += 3;
        if (led_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_led: led_out=%h required 00", led_out);
        end
        if (frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick: frame_tick=%b required 0", frame_tick);
        end
        if (cfg_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending: cfg_pending=%b required 0", cfg_pending);
        end
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            capture_frame(-1, 32'h0);
            bad = frame_diff(8'hFF, 8'hFF, 256);
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL default_steady f%0d: led_out[%0d]=%h required ff", f, bad, led_hist[bad]);
            end
            bad = tick_diff();
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL default_tick f%0d: frame_tick[%0d]=%b required %b", f, bad, tick_hist[bad], bad == 255);
            end
        end
    endtask

    task automatic test_duty();
        int bad;
        apply_cfg(32'h0000_400F);
        for (int f = 0; f < 2; f++) begin
            capture_frame(-1, 32'h0);
            bad = frame_diff(8'h0F, 8'h00, 64);
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL duty64 f%0d: led_out[%0d]=%h required %h", f, bad, led_hist[bad], (bad < 64) ? 8'h0F : 8'h00);
            end
        end
    endtask

    task automatic test_deferred_load();
        int bad;
        capture_frame(99, 32'h0000_0003);
        bad = frame_diff(8'h0F, 8'h00, 64);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL deferred_hold: led_out[%0d]=%h required %h", bad, led_hist[bad], (bad < 64) ? 8'h0F : 8'h00);
        end
        bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (bad < 0 && pend_hist[i] !== 1'(i >= 101)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL deferred_pending: cfg_pending[%0d]=%b required %b", bad, pend_hist[bad], bad >= 101);
        end
        capture_frame(-1, 32'h0);
        bad = frame_diff(8'h03, 8'h03, 256);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL deferred_loaded: led_out[%0d]=%h required 03", bad, led_hist[bad]);
        end
        bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (bad < 0 && pend_hist[i] !== 1'b0) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL deferred_pending_clear: cfg_pending[%0d]=%b required 0", bad, pend_hist[bad]);
        end
    endtask

    // Several changes in one frame; the one landing in the boundary cycle waits a frame.
    task automatic test_back_to_back();
        int bad;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            led_hist[i] = led_out;
            case (i)
                10:      pattern_in = 32'h0000_0001;
                100:     pattern_in = 32'h0000_0002;
                200:     pattern_in = 32'h0000_0004;
                254:     pattern_in = 32'h0000_0008;
                default: ;
            endcase
        end
        bad = frame_diff(8'h03, 8'h03, 256);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL b2b_hold: led_out[%0d]=%h required 03", bad, led_hist[bad]);
        end
        capture_frame(-1, 32'h0);
        bad = frame_diff(8'h04, 8'h04, 256);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL b2b_last_before_boundary: led_out[%0d]=%h required 04", bad, led_hist[bad]);
        end
        capture_frame(-1, 32'h0);
        bad = frame_diff(8'h08, 8'h08, 256);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL b2b_boundary_change: led_out[%0d]=%h required 08", bad, led_hist[bad]);
        end
    endtask

    task automatic test_blink();
        int bad;
        logic [7:0] e;
        apply_cfg(32'h0001_00FF);
        for (int f = 0; f < 4; f++) begin
            capture_frame(-1, 32'h0);
            e = (f % 2 == 0) ? 8'hFF : 8'h00;
            bad = frame_diff(e, e, 256);
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL blink_r1 f%0d: led_out[%0d]=%h required %h", f, bad, led_hist[bad], e);
            end
        end
        apply_cfg(32'h0002_00FF);
        for (int f = 0; f < 4; f++) begin
            capture_frame(-1, 32'h0);
            e = (f < 2) ? 8'hFF : 8'h00;
            bad = frame_diff(e, e, 256);
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL blink_r2 f%0d: led_out[%0d]=%h required %h", f, bad, led_hist[bad], e);
            end
        end
    endtask

    task automatic test_invert_reset();
        int bad;
        apply_cfg(32'h0010_0003);
        capture_frame(-1, 32'h0);
        bad = frame_diff(8'hFC, 8'hFC, 256);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL invert: led_out[%0d]=%h required fc", bad, led_hist[bad]);
        end
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (led_out !== 8'h00) begin
            failures++;
            $display("FAIL midframe_reset_led: led_out=%h required 00", led_out);
        end
        if (frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset_tick: frame_tick=%b required 0", frame_tick);
        end
        if (cfg_pending !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset_pending: cfg_pending=%b required 0", cfg_pending);
        end
        @(negedge clk);
        reset = 1'b0;
        capture_frame(-1, 32'h0);
        bad = frame_diff(8'hFF, 8'hFF, 256);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL post_reset_default: led_out[%0d]=%h required ff", bad, led_hist[bad]);
        end
        bad = tick_diff();
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL post_reset_tick: frame_tick[%0d]=%b required %b", bad, tick_hist[bad], bad == 255);
        end
        capture_frame(-1, 32'h0);
        bad = frame_diff(8'hFC, 8'hFC, 256);
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL post_reset_reload: led_out[%0d]=%h required fc", bad, led_hist[bad]);
        end
    endtask

    task automatic test_gamma();
        logic [31:0] vec [4] = '{32'h0000_80FF, 32'h0000_FFFF, 32'h0000_10FF, 32'h0000_05FF};
`ifdef LED_GAMMA_EN
        int duty [4] = '{64, 254, 1, 1};
`else
        int duty [4] = '{128, 255, 16, 5};
`endif
        int bad;
        for (int k = 0; k < 4; k++) begin
            apply_cfg(vec[k]);
            capture_frame(-1, 32'h0);
            bad = frame_diff(8'hFF, 8'h00, duty[k]);
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL duty_map cfg=%h: led_out[%0d]=%h required %h", vec[k], bad, led_hist[bad],
                         (bad < duty[k]) ? 8'hFF : 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_deferred_load();
        test_back_to_back();
        test_blink();
        test_invert_reset();
        test_gamma();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
